arb_field_serializer: RTL and testbench
=======================================

// Module: arb_field_serializer
// PURPOSE
//  Downstream of the identifier latch in FRAME MAKER: takes the latched 29-bit identifier plus IDE/RTR
//  and serialises SOF + arbitration field + IDE/reserved bits onto the bus, one bit per SP edge, MSB first.
//  Inserts CAN bit stuffing, monitors rx_bit for arbitration loss and bit errors, and hands stuffing
//  state to the following control/data-field stage.
// PARAMETERS
//  STUFF_LEN  5   identical consecutive bits that force a stuff bit
// PORTS
//  SP            in   1   bit-rate clock (one edge per bit time at the sample point)
//  reset         in   1   asynchronous, active-low reset
//  start         in   1   begin a frame; sampled only in IDLE
//  IDTFR         in   29  [10:0] base ID, [28:11] extended ID
//  IDE           in   1   0 = standard frame, 1 = extended frame
//  RTR           in   1   remote-request bit value
//  rx_bit        in   1   bus level at the sample point
//  tx_bit        out  1   bit driven to the bus (1 = recessive)
//  busy          out  1   serializer owns the bus
//  is_stuff      out  1   current tx_bit is a stuff bit
//  done          out  1   1-cycle pulse: field complete, next stage takes over
//  arb_lost      out  1   1-cycle pulse: lost arbitration
//  bit_err       out  1   1-cycle pulse: drove dominant, read recessive
//  run_len_out   out  3   length of current identical-bit run at handoff (1..5)
//  last_bit_out  out  1   value of last transmitted bit at handoff
// BEHAVIOUR
//  Reset (async, reset=0): IDLE; tx_bit=1, busy=0, is_stuff=0, done=0, arb_lost=0, bit_err=0,
//   run_len_out=0, last_bit_out=1; run counter cleared. Reset mid-frame aborts immediately, no pulses.
//  Bit sequence, standard (IDE=0, 15 bits): SOF=0, ID[10:0], RTR, IDE=0, r0=0.
//  Bit sequence, extended (IDE=1, 35 bits): SOF=0, ID[10:0], SRR=1, IDE=1, EX[17:0], RTR, r1=0, r0=0.
//  IDTFR/IDE/RTR captured into an internal shift register on the start edge; later input changes ignored.
//  FSM: IDLE -> SEND on start; SEND -> IDLE at end of field (done), on arb_lost, or on bit_err.
//  Latency: edge that samples start drives SOF (tx_bit=0, busy=1); each following edge drives next bit.
//  Stuffing: run counter tracks consecutive equal transmitted bits (stuff bits included, SOF starts run=1).
//   When run reaches STUFF_LEN, next edge drives ~last bit with is_stuff=1, run restarts at 1; the
//   frame bit index does not advance on a stuff edge.
//  Monitoring: each edge compares rx_bit with the tx_bit driven during the bit just ended.
//   Arbitration window = ID bits, SRR, IDE, EX bits, RTR (not SOF, r1, r0, stuff bits).
//   tx=1, rx=0 inside window -> arb_lost=1 one cycle, tx_bit=1, busy=0, IDLE.
//   tx=0, rx=1 on any bit incl. stuff -> bit_err=1 one cycle, tx_bit=1, busy=0, IDLE.
//   tx=1, rx=0 outside window (stuff, r1, r0) -> bit_err. Both conditions never coincide.
//  End: edge after r0 driven (and checked): done=1 one cycle, busy=0, tx_bit=1, run_len_out/last_bit_out
//   hold run state incl. r0; no trailing stuff bit inserted here (run_len_out=5 tells next stage to stuff).
//   run_len_out/last_bit_out hold until next start.
//  start while busy is ignored; start on the done edge is ignored (accepted next IDLE edge).
// STRUCTURE
//  Shared package can_frame_pkg: RECESSIVE/DOMINANT, SOF_BIT, STUFF_LEN default, STD_ARB_BITS=15,
//   EXT_ARB_BITS=35, FSM state enum (IDLE, SEND), field-index constants for window boundaries.
//  One sub-module: can_bit_stuffer (run counter, stuff-request, last-bit tracking), reused by the
//   data/CRC serializer downstream.
// TESTING
//  1 Std, IDTFR=0, RTR=0, rx=tx -> 17 busy cycles: 00000 1 00000 1 00000, stuff at 6 and 12,
//    done; run_len_out=5, last_bit_out=0.
//  2 Ext, IDTFR[10:0]=11'h555, IDTFR[28:11]=18'h2AAAA, RTR=1, rx=tx -> 35 bits, no stuff bits,
//    done after 35 busy cycles, last_bit_out=0.
//  3 Std ID 11'h400, rx forced 0 during ID10 -> arb_lost pulse on the next edge, tx_bit=1, busy=0.
//  4 Std ID 0, rx forced 1 during first stuff position -> no pulse while ID bits are 0 and rx=0;
//    force rx=1 on a dominant bit -> bit_err pulse, IDLE.
//  5 reset pulsed low mid-frame (bit 8) -> all outputs to reset values asynchronously; new start works.
//  6 start held high through a frame and the done edge -> second frame begins one edge after done.

Source files
------------

// File: rtl/can_frame_pkg.sv
// ============================================================================
// Module   : can_frame_pkg
// Brief    : Shared CAN frame constants, FSM state type and frame builder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package can_frame_pkg;

   localparam logic RECESSIVE     = 1'b1;
   localparam logic DOMINANT      = 1'b0;
   localparam logic SOF_BIT       = DOMINANT;
   localparam int   STUFF_LEN_DEF = 5;

   localparam int   STD_ARB_BITS  = 15;
   localparam int   EXT_ARB_BITS  = 35;
   localparam int   IDX_W         = 6;

   // Frame-bit indices bounding the arbitration window (SOF=0 is outside).
   localparam int   WIN_FIRST     = 1;
   localparam int   STD_WIN_LAST  = 13;
   localparam int   EXT_WIN_LAST  = 32;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Arbitration field left-aligned in EXT_ARB_BITS, MSB transmitted first.
   function automatic logic [EXT_ARB_BITS-1:0] build_frame(
      input logic [28:0] id,
      input logic        ide,
      input logic        rtr
   );
      if (ide)
         return {SOF_BIT, id[10:0], RECESSIVE, RECESSIVE, id[28:11],
                 rtr, DOMINANT, DOMINANT};
      else
         return {SOF_BIT, id[10:0], rtr, DOMINANT, DOMINANT,
                 {(EXT_ARB_BITS-STD_ARB_BITS){1'b0}}};
   endfunction

endpackage

`default_nettype wire

// File: rtl/can_bit_stuffer.sv
// ============================================================================
// Module   : can_bit_stuffer
// Brief    : Run-length tracker for CAN bit stuffing (run counter, last bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module can_bit_stuffer
   import can_frame_pkg::*;
#(
   parameter int STUFF_LEN = STUFF_LEN_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic       i_push,
   input  logic       i_bit,
   output logic [2:0] o_run_len,
   output logic       o_last_bit,
   output logic       o_stuff_req
);

   localparam logic [2:0] c_STUFF_LEN = 3'(STUFF_LEN);

   logic [2:0] r_run;
   logic       r_last;

   // i_start opens a fresh run regardless of what the previous frame left.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_run  <= '0;
         r_last <= RECESSIVE;
      end else if (i_start) begin
         r_run  <= 3'd1;
         r_last <= i_bit;
      end else if (i_push) begin
         r_run  <= (i_bit == r_last) ? r_run + 3'd1 : 3'd1;
         r_last <= i_bit;
      end
   end

   assign o_run_len   = r_run;
   assign o_last_bit  = r_last;
   assign o_stuff_req = (r_run == c_STUFF_LEN);

endmodule

`default_nettype wire

// File: rtl/arb_field_serializer.sv
// ============================================================================
// Module   : arb_field_serializer
// Brief    : Serialises SOF + CAN arbitration field with stuffing and monitoring.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_field_serializer
   import can_frame_pkg::*;
#(
   parameter int STUFF_LEN = STUFF_LEN_DEF
) (
   input  logic        SP,
   input  logic        reset,
   input  logic        start,
   input  logic [28:0] IDTFR,
   input  logic        IDE,
   input  logic        RTR,
   input  logic        rx_bit,
   output logic        tx_bit,
   output logic        busy,
   output logic        is_stuff,
   output logic        done,
   output logic        arb_lost,
   output logic        bit_err,
   output logic [2:0]  run_len_out,
   output logic        last_bit_out
);

   localparam int c_MSB = EXT_ARB_BITS - 1;

   state_t                  r_state, w_state;
   logic [EXT_ARB_BITS-1:0] r_shift, w_shift, w_frame;
   logic [IDX_W-1:0]        r_idx, w_idx, w_win_last, w_frame_last;
   logic                    r_ext, w_ext;
   logic                    r_tx, w_tx;
   logic                    r_busy, w_busy;
   logic                    r_is_stuff, w_is_stuff;
   logic                    r_done, w_done;
   logic                    r_arb, w_arb;
   logic                    r_berr, w_berr;
   logic                    w_stf_start, w_stf_push, w_stf_bit;
   logic                    w_stuff_req, w_last_bit;
   logic [2:0]              w_run_len;
   logic                    w_in_win, w_lost, w_err;

   can_bit_stuffer #(.STUFF_LEN(STUFF_LEN)) u_stuffer (
      .clk         (SP),
      .reset       (reset),
      .i_start     (w_stf_start),
      .i_push      (w_stf_push),
      .i_bit       (w_stf_bit),
      .o_run_len   (w_run_len),
      .o_last_bit  (w_last_bit),
      .o_stuff_req (w_stuff_req)
   );

   assign w_frame      = build_frame(IDTFR, IDE, RTR);
   assign w_win_last   = r_ext ? IDX_W'(EXT_WIN_LAST)     : IDX_W'(STD_WIN_LAST);
   assign w_frame_last = r_ext ? IDX_W'(EXT_ARB_BITS - 1) : IDX_W'(STD_ARB_BITS - 1);

   // r_tx/r_idx/r_is_stuff describe the bit that just ended at this edge.
   assign w_in_win = !r_is_stuff && (r_idx >= IDX_W'(WIN_FIRST)) && (r_idx <= w_win_last);
   assign w_lost   = (r_tx == RECESSIVE) && (rx_bit == DOMINANT) && w_in_win;
   assign w_err    = (r_tx != rx_bit) && !w_lost;

   always_ff @(posedge SP or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_idx      <= '0;
         r_ext      <= 1'b0;
         r_tx       <= RECESSIVE;
         r_busy     <= 1'b0;
         r_is_stuff <= 1'b0;
         r_done     <= 1'b0;
         r_arb      <= 1'b0;
         r_berr     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_shift    <= w_shift;
         r_idx      <= w_idx;
         r_ext      <= w_ext;
         r_tx       <= w_tx;
         r_busy     <= w_busy;
         r_is_stuff <= w_is_stuff;
         r_done     <= w_done;
         r_arb      <= w_arb;
         r_berr     <= w_berr;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_shift     = r_shift;
      w_idx       = r_idx;
      w_ext       = r_ext;
      w_tx        = r_tx;
      w_busy      = r_busy;
      w_is_stuff  = r_is_stuff;
      w_done      = 1'b0;
      w_arb       = 1'b0;
      w_berr      = 1'b0;
      w_stf_start = 1'b0;
      w_stf_push  = 1'b0;
      w_stf_bit   = DOMINANT;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state     = SEND;
               w_shift     = w_frame << 1;
               w_idx       = '0;
               w_ext       = IDE;
               w_tx        = w_frame[c_MSB];
               w_busy      = 1'b1;
               w_is_stuff  = 1'b0;
               w_stf_start = 1'b1;
               w_stf_bit   = w_frame[c_MSB];
            end
         end
         SEND: begin
            if (w_lost || w_err) begin
               w_state    = IDLE;
               w_tx       = RECESSIVE;
               w_busy     = 1'b0;
               w_is_stuff = 1'b0;
               w_arb      = w_lost;
               w_berr     = w_err;
            end else if (!r_is_stuff && (r_idx == w_frame_last)) begin
               // No trailing stuff here: the next stage sees run_len_out and stuffs.
               w_state    = IDLE;
               w_tx       = RECESSIVE;
               w_busy     = 1'b0;
               w_is_stuff = 1'b0;
               w_done     = 1'b1;
            end else if (w_stuff_req) begin
               w_tx       = ~w_last_bit;
               w_is_stuff = 1'b1;
               w_stf_push = 1'b1;
               w_stf_bit  = ~w_last_bit;
            end else begin
               w_tx       = r_shift[c_MSB];
               w_shift    = r_shift << 1;
               w_idx      = r_idx + IDX_W'(1);
               w_is_stuff = 1'b0;
               w_stf_push = 1'b1;
               w_stf_bit  = r_shift[c_MSB];
            end
         end
         default: w_state = IDLE;
      endcase
   end

   assign tx_bit       = r_tx;
   assign busy         = r_busy;
   assign is_stuff     = r_is_stuff;
   assign done         = r_done;
   assign arb_lost     = r_arb;
   assign bit_err      = r_berr;
   assign run_len_out  = w_run_len;
   assign last_bit_out = w_last_bit;

endmodule

`default_nettype wire

// File: tb/tb_arb_field_serializer.sv
// ============================================================================
// Module   : tb_arb_field_serializer
// Brief    : Directed, scoreboard-based bench for arb_field_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arb_field_serializer;

   logic        SP = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [28:0] IDTFR = '0;
   logic        IDE = 1'b0;
   logic        RTR = 1'b0;
   logic        rx_force_en = 1'b0;
   logic        rx_force_val = 1'b0;
   logic        rx_bit;
   logic        tx_bit, busy, is_stuff, done, arb_lost, bit_err, last_bit_out;
   logic [2:0]  run_len_out;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic tx;
      logic stuff;
   } exp_t;

   exp_t       exp_q[$];
   logic [2:0] m_run;
   logic       m_last;

   always #5 SP = ~SP;

   // Loopback bus unless a test overrides the level seen at the sample point.
   assign rx_bit = rx_force_en ? rx_force_val : tx_bit;

   arb_field_serializer dut (
      .SP           (SP),
      .reset        (reset),
      .start        (start),
      .IDTFR        (IDTFR),
      .IDE          (IDE),
      .RTR          (RTR),
      .rx_bit       (rx_bit),
      .tx_bit       (tx_bit),
      .busy         (busy),
      .is_stuff     (is_stuff),
      .done         (done),
      .arb_lost     (arb_lost),
      .bit_err      (bit_err),
      .run_len_out  (run_len_out),
      .last_bit_out (last_bit_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: build frame bits, then apply stuffing (no trailing stuff bit).
   task automatic push_model(input logic [28:0] id, input logic ide, input logic rtr);
      logic       fb[$];
      logic [2:0] run;
      logic       last;
      fb.push_back(1'b0);
      for (int i = 10; i >= 0; i--) fb.push_back(id[i]);
      if (ide) begin
         fb.push_back(1'b1);
         fb.push_back(1'b1);
         for (int i = 28; i >= 11; i--) fb.push_back(id[i]);
      end
      fb.push_back(rtr);
      fb.push_back(1'b0);
      fb.push_back(1'b0);
      run  = 3'd0;
      last = 1'b1;
      foreach (fb[k]) begin
         if (run == 3'd5) begin
            last = ~last;
            run  = 3'd1;
            exp_q.push_back({last, 1'b1});
         end
         if (run != 3'd0 && fb[k] == last) run = run + 3'd1;
         else run = 3'd1;
         last = fb[k];
         exp_q.push_back({fb[k], 1'b0});
      end
      m_run  = run;
      m_last = last;
   endtask

   task automatic launch(input logic [28:0] id, input logic ide, input logic rtr);
      @(negedge SP);
      IDTFR = id;
      IDE   = ide;
      RTR   = rtr;
      start = 1'b1;
      push_model(id, ide, rtr);
      @(posedge SP); #1;
   endtask

   task automatic scramble();
      start = 1'b0;
      IDTFR = 29'($urandom);
      IDE   = ~IDE;
      RTR   = ~RTR;
   endtask

   // Entered #1 after the edge that drove the first queued bit.
   task automatic drain(input string name, input int exp_cycles);
      exp_t e;
      int   cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (busy === 1'b1) cyc++;
         check({name, ".tx"}, 32'(tx_bit), 32'(e.tx));
         check({name, ".stuff"}, 32'(is_stuff), 32'(e.stuff));
         @(posedge SP); #1;
      end
      check({name, ".busy_cycles"}, 32'(cyc), 32'(exp_cycles));
      check({name, ".done"}, 32'(done), 32'd1);
      check({name, ".busy_end"}, 32'(busy), 32'd0);
      check({name, ".tx_end"}, 32'(tx_bit), 32'd1);
      check({name, ".arb_lost"}, 32'(arb_lost), 32'd0);
      check({name, ".bit_err"}, 32'(bit_err), 32'd0);
      check({name, ".run_len"}, 32'(run_len_out), 32'(m_run));
      check({name, ".last_bit"}, 32'(last_bit_out), 32'(m_last));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge SP);
      #1;
      check("rst.tx", 32'(tx_bit), 32'd1);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.run_len", 32'(run_len_out), 32'd0);
      check("rst.last_bit", 32'(last_bit_out), 32'd1);
      @(negedge SP);
      reset = 1'b1;

      // 1: standard, all-zero ID -> two stuff bits
      launch(29'h0, 1'b0, 1'b0);
      scramble();
      drain("t1", 17);
      check("t1.run_len5", 32'(run_len_out), 32'd5);
      check("t1.last0", 32'(last_bit_out), 32'd0);

      // 2: extended alternating pattern, no stuffing
      launch({18'h2AAAA, 11'h555}, 1'b1, 1'b1);
      scramble();
      drain("t2", 35);
      check("t2.last0", 32'(last_bit_out), 32'd0);

      // 3: arbitration lost on ID10
      launch(29'h400, 1'b0, 1'b0);
      scramble();
      exp_q.delete();
      check("t3.sof", 32'(tx_bit), 32'd0);
      check("t3.busy", 32'(busy), 32'd1);
      @(posedge SP); #1;
      check("t3.id10", 32'(tx_bit), 32'd1);
      rx_force_en  = 1'b1;
      rx_force_val = 1'b0;
      @(posedge SP); #1;
      check("t3.arb_lost", 32'(arb_lost), 32'd1);
      check("t3.bit_err", 32'(bit_err), 32'd0);
      check("t3.busy_end", 32'(busy), 32'd0);
      check("t3.tx_end", 32'(tx_bit), 32'd1);
      rx_force_en = 1'b0;
      @(posedge SP); #1;
      check("t3.pulse_end", 32'(arb_lost), 32'd0);

      // 4: recessive stuff bit read recessive is fine; dominant read recessive errors
      launch(29'h0, 1'b0, 1'b0);
      scramble();
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         @(posedge SP); #1;
         check("t4.zero", 32'(tx_bit), 32'd0);
      end
      @(posedge SP); #1;
      check("t4.stuff", 32'(is_stuff), 32'd1);
      check("t4.stuff_tx", 32'(tx_bit), 32'd1);
      rx_force_en  = 1'b1;
      rx_force_val = 1'b1;
      @(posedge SP); #1;
      check("t4.no_err", 32'(bit_err), 32'd0);
      check("t4.no_arb", 32'(arb_lost), 32'd0);
      check("t4.busy", 32'(busy), 32'd1);
      check("t4.id6", 32'(tx_bit), 32'd0);
      @(posedge SP); #1;
      check("t4.bit_err", 32'(bit_err), 32'd1);
      check("t4.arb0", 32'(arb_lost), 32'd0);
      check("t4.busy_end", 32'(busy), 32'd0);
      check("t4.tx_end", 32'(tx_bit), 32'd1);
      rx_force_en = 1'b0;
      @(posedge SP); #1;
      check("t4.pulse_end", 32'(bit_err), 32'd0);

      // 4b: recessive stuff bit read dominant is a bit error, not arbitration loss
      launch(29'h0, 1'b0, 1'b0);
      scramble();
      exp_q.delete();
      repeat (5) @(posedge SP);
      #1;
      check("t4b.stuff", 32'(is_stuff), 32'd1);
      rx_force_en  = 1'b1;
      rx_force_val = 1'b0;
      @(posedge SP); #1;
      check("t4b.bit_err", 32'(bit_err), 32'd1);
      check("t4b.arb0", 32'(arb_lost), 32'd0);
      check("t4b.busy_end", 32'(busy), 32'd0);
      rx_force_en = 1'b0;

      // 5: asynchronous reset mid-frame, then a fresh frame
      launch(29'h123, 1'b0, 1'b1);
      scramble();
      exp_q.delete();
      repeat (8) @(posedge SP);
      #1;
      check("t5.busy_mid", 32'(busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("t5.tx", 32'(tx_bit), 32'd1);
      check("t5.busy", 32'(busy), 32'd0);
      check("t5.stuff", 32'(is_stuff), 32'd0);
      check("t5.done", 32'(done), 32'd0);
      check("t5.arb", 32'(arb_lost), 32'd0);
      check("t5.err", 32'(bit_err), 32'd0);
      check("t5.run_len", 32'(run_len_out), 32'd0);
      check("t5.last_bit", 32'(last_bit_out), 32'd1);
      @(negedge SP);
      reset = 1'b1;
      launch(29'h7F0, 1'b0, 1'b1);
      scramble();
      drain("t5n", 16);

      // 6: start held high across the done edge
      launch(29'h2A5, 1'b0, 1'b0);
      drain("t6a", 15);
      push_model(29'h2A5, 1'b0, 1'b0);
      @(posedge SP); #1;
      start = 1'b0;
      check("t6.done_drop", 32'(done), 32'd0);
      check("t6.restart_busy", 32'(busy), 32'd1);
      drain("t6b", 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
